// File: rtl/msg_sequencer.sv
// -----------------------------------------------------------------------------
// msg_sequencer
//
// Control stage for the sale terminal's 11-way display-pattern multiplexer.
// It steps the multiplexer select code through message slots 0..LAST_SEL.
// Each slot is shown for DWELL_CYCLES cycles with the mux enabled. It is then
// followed by BLANK_CYCLES cycles with the mux disabled (no gap when 0).
// Playback is one-shot or looping.
//
// Parameters
//   DWELL_CYCLES : cycles each slot is shown (>= 1)
//   BLANK_CYCLES : blank cycles after each slot (0 = no gap)
//   LAST_SEL     : final select code of a sequence (0..10)
//
// Ports
//   clk       in  : system clock, rising edge
//   rst_n     in  : asynchronous active-low reset
//   start     in  : start request, honoured only while idle
//   stop      in  : abort request, dominates every other event
//   loop      in  : 1 = wrap to slot 0 after LAST_SEL, 0 = one-shot
//   sel       out : 4-bit mux select code (registered)
//   mux_en    out : mux enable (registered)
//   busy      out : high while a sequence is showing or blanking
//   slot_tick out : one-cycle pulse on each slot advance or wrap
//   done      out : one-cycle pulse when a one-shot sequence completes
// -----------------------------------------------------------------------------
module msg_sequencer #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLANK_CYCLES = 5_000_000,
  parameter int LAST_SEL     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [3:0] sel,
  output logic       mux_en,
  output logic       busy,
  output logic       slot_tick,
  output logic       done
);

  // The counter only has to reach the longer of the two phase lengths.
  localparam int MAX_DB    = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_RANGE = (MAX_DB > 2) ? MAX_DB : 2;
  localparam int CW        = $clog2(CNT_RANGE);

  localparam logic [CW-1:0] DWELL_END = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [3:0]    LAST      = 4'(LAST_SEL);
  localparam bit            HAS_GAP   = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          slot_end;

  // A slot ends at the last gap cycle. Without a gap, it ends at the last dwell cycle.
  assign slot_end = (state == SHOW && cnt == DWELL_END && !HAS_GAP) ||
                    (state == GAP  && cnt == BLANK_END);

  // NOTE: every register, including the counter, is cleared asynchronously so
  // the outputs drop the instant rst_n falls, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      mux_en    <= 1'b0;
      busy      <= 1'b0;
      slot_tick <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout. The pulse defaults below are
      // overridden later in the same block, and the last assignment wins.
      slot_tick <= 1'b0;
      done      <= 1'b0;

      if (state != IDLE && stop) begin
        // Abort takes priority over any coincident slot advance.
        state  <= IDLE;
        cnt    <= '0;
        sel    <= '0;
        mux_en <= 1'b0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !stop) begin
              state  <= SHOW;
              cnt    <= '0;
              sel    <= '0;
              mux_en <= 1'b1;
              busy   <= 1'b1;
            end
          end

          SHOW, GAP: begin
            if (slot_end) begin
              cnt <= '0;
              if (sel < LAST) begin
                sel       <= sel + 4'd1;
                state     <= SHOW;
                mux_en    <= 1'b1;
                slot_tick <= 1'b1;
              end else if (loop) begin
                sel       <= '0;
                state     <= SHOW;
                mux_en    <= 1'b1;
                slot_tick <= 1'b1;
              end else begin
                sel    <= '0;
                state  <= IDLE;
                mux_en <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end
            end else if (state == SHOW && cnt == DWELL_END) begin
              state  <= GAP;
              cnt    <= '0;
              mux_en <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_msg_sequencer
//
// Three sequencer instances with different parameter sets share one clock:
//   a : DWELL=4, BLANK=2, LAST_SEL=2   (one-shot, stop, start-while-busy)
//   b : DWELL=3, BLANK=0, LAST_SEL=10  (looping, asynchronous reset)
//   c : DWELL=2, BLANK=1, LAST_SEL=1   (loop cleared mid-sequence)
// Expected outputs come from a timeline model of cycle t after the start edge.
// The slot number is t/(DWELL+BLANK) and the phase is t%(DWELL+BLANK).
// -----------------------------------------------------------------------------
module tb_msg_sequencer;

  typedef struct packed {
    logic [3:0] sel;
    logic       mux_en;
    logic       busy;
    logic       slot_tick;
    logic       done;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       a_rst_n, a_start, a_stop, a_loop;
  logic [3:0] a_sel;
  logic       a_mux_en, a_busy, a_slot_tick, a_done;
  logic       b_rst_n, b_start, b_stop, b_loop;
  logic [3:0] b_sel;
  logic       b_mux_en, b_busy, b_slot_tick, b_done;
  logic       c_rst_n, c_start, c_stop, c_loop;
  logic [3:0] c_sel;
  logic       c_mux_en, c_busy, c_slot_tick, c_done;

  msg_sequencer #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .LAST_SEL(2)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .start(a_start), .stop(a_stop), .loop(a_loop),
    .sel(a_sel), .mux_en(a_mux_en), .busy(a_busy), .slot_tick(a_slot_tick), .done(a_done)
  );

  msg_sequencer #(.DWELL_CYCLES(3), .BLANK_CYCLES(0), .LAST_SEL(10)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .start(b_start), .stop(b_stop), .loop(b_loop),
    .sel(b_sel), .mux_en(b_mux_en), .busy(b_busy), .slot_tick(b_slot_tick), .done(b_done)
  );

  msg_sequencer #(.DWELL_CYCLES(2), .BLANK_CYCLES(1), .LAST_SEL(1)) dut_c (
    .clk(clk), .rst_n(c_rst_n), .start(c_start), .stop(c_stop), .loop(c_loop),
    .sel(c_sel), .mux_en(c_mux_en), .busy(c_busy), .slot_tick(c_slot_tick), .done(c_done)
  );

  // Expected outputs t cycles after the start edge (t=0 is the first busy cycle).
  // lp is the loop level seen at the final-slot advance.
  function automatic obs_t model(int t, int d, int b, int l, bit lp);
    obs_t e;
    int   per;
    int   total;
    e     = '0;
    per   = d + b;
    total = (l + 1) * per;
    if (t < 0) return e;
    if (!lp && t >= total) begin
      e.done = (t == total);
      return e;
    end
    e.busy      = 1'b1;
    e.sel       = 4'((t / per) % (l + 1));
    e.mux_en    = (t % per) < d;
    e.slot_tick = (t > 0) && (t % per == 0);
    return e;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("sel=%0d en=%b busy=%b tick=%b done=%b",
                     o.sel, o.mux_en, o.busy, o.slot_tick, o.done);
  endfunction

  function automatic obs_t obs_a();
    return {a_sel, a_mux_en, a_busy, a_slot_tick, a_done};
  endfunction

  function automatic obs_t obs_b();
    return {b_sel, b_mux_en, b_busy, b_slot_tick, b_done};
  endfunction

  function automatic obs_t obs_c();
    return {c_sel, c_mux_en, c_busy, c_slot_tick, c_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t want;
    want = '0;
    #3;
    got = obs_a(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_a: got %s want %s", fmt(got), fmt(want)); end
    got = obs_b(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_b: got %s want %s", fmt(got), fmt(want)); end
    got = obs_c(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_c: got %s want %s", fmt(got), fmt(want)); end
    #4;
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = obs_a(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL post_reset_idle_a: got %s want %s", fmt(got), fmt(want)); end
    end
  endtask

  // One-shot gapped run with random loop levels at the intermediate advances.
  // Loop is forced low for the final advance, then a start in the done cycle
  // restarts the sequence.
  task automatic test_one_shot();
    obs_t got;
    obs_t want;
    int   ticks;
    int   dones;
    int   w;
    ticks = 0;
    dones = 0;
    w = int'($urandom_range(0, 3));
    for (int i = 0; i < w; i++) begin
      tick();
      got = obs_a(); want = '0; n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL one_shot_idle: got %s want %s", fmt(got), fmt(want)); end
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int t = 0; t <= 18; t++) begin
      got = obs_a(); want = model(t, 4, 2, 2, 1'b0); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL one_shot t=%0d: got %s want %s", t, fmt(got), fmt(want)); end
      if (got.slot_tick === 1'b1) ticks++;
      if (got.done === 1'b1) dones++;
      if (t < 18) begin
        a_loop = (t == 17) ? 1'b0 : 1'($urandom);
        tick();
      end
    end
    n_checks++;
    if (ticks != 2) begin n_fail++; $display("FAIL one_shot_tick_count: got %0d want 2", ticks); end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL one_shot_done_count: got %0d want 1", dones); end
    a_loop  = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int t = 0; t <= 5; t++) begin
      got = obs_a(); want = model(t, 4, 2, 2, 1'b0); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL restart_after_done t=%0d: got %s want %s", t, fmt(got), fmt(want)); end
      tick();
    end
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    got = obs_a(); want = '0; n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL restart_stop: got %s want %s", fmt(got), fmt(want)); end
  endtask

  // Stop at the second gap cycle of slot 1 and at the final advance.
  // A third stop lands at a random cycle.
  task automatic test_stop();
    obs_t got;
    obs_t want;
    int   stops [3];
    stops[0] = 11;
    stops[1] = 17;
    stops[2] = int'($urandom_range(0, 16));
    a_loop = 1'b0;
    for (int r = 0; r < 3; r++) begin
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int t = 0; t <= stops[r]; t++) begin
        got = obs_a(); want = model(t, 4, 2, 2, 1'b0); n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL stop_run%0d t=%0d: got %s want %s", r, t, fmt(got), fmt(want)); end
        if (t == stops[r]) a_stop = 1'b1;
        tick();
      end
      a_stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
        got = obs_a(); want = '0; n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL stop_idle run%0d at=%0d +%0d: got %s want %s", r, stops[r], i, fmt(got), fmt(want)); end
        tick();
      end
    end
  endtask

  // Start pulses while busy must not disturb timing; start+stop in idle stays idle.
  task automatic test_start_collision();
    obs_t got;
    obs_t want;
    a_loop  = 1'b0;
    a_start = 1'b1;
    tick();
    for (int t = 0; t <= 18; t++) begin
      got = obs_a(); want = model(t, 4, 2, 2, 1'b0); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL start_while_busy t=%0d: got %s want %s", t, fmt(got), fmt(want)); end
      if (t < 18) begin
        a_start = (t == 7) || ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    a_start = 1'b1;
    a_stop  = 1'b1;
    tick();
    a_start = 1'b0;
    a_stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = obs_a(); want = '0; n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL start_stop_idle +%0d: got %s want %s", i, fmt(got), fmt(want)); end
      tick();
    end
  endtask

  // Looping with no gap: sel runs 0..10 and wraps; mux stays enabled; no done.
  task automatic test_loop();
    obs_t got;
    obs_t want;
    int   dones;
    dones  = 0;
    b_loop = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int t = 0; t < 45; t++) begin
      got = obs_b(); want = model(t, 3, 0, 10, 1'b1); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL loop t=%0d: got %s want %s", t, fmt(got), fmt(want)); end
      if (got.done === 1'b1) dones++;
      tick();
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL loop_no_done: got %0d want 0", dones); end
    b_stop = 1'b1;
    tick();
    b_stop = 1'b0;
  endtask

  // Reset dropped between edges while sel=5 clears outputs immediately.
  task automatic test_async_reset();
    obs_t got;
    obs_t want;
    b_loop  = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int t = 0; t <= 16; t++) begin
      got = obs_b(); want = model(t, 3, 0, 10, 1'b1); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL pre_reset t=%0d: got %s want %s", t, fmt(got), fmt(want)); end
      if (t < 16) tick();
    end
    #2;
    b_rst_n = 1'b0;
    #1;
    got = obs_b(); want = '0; n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL async_reset_immediate: got %s want %s", fmt(got), fmt(want)); end
    tick();
    tick();
    #3;
    b_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = obs_b(); want = '0; n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL after_reset_idle +%0d: got %s want %s", i, fmt(got), fmt(want)); end
    end
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int t = 0; t <= 5; t++) begin
      got = obs_b(); want = model(t, 3, 0, 10, 1'b1); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL fresh_after_reset t=%0d: got %s want %s", t, fmt(got), fmt(want)); end
      tick();
    end
    b_stop = 1'b1;
    tick();
    b_stop = 1'b0;
  endtask

  // Loop cleared during slot 1 ends with done. Loop held high wraps to slot 0.
  task automatic test_loop_clear();
    obs_t got;
    obs_t want;
    int   k;
    k = int'($urandom_range(3, 5));
    c_loop  = 1'b1;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int t = 0; t <= 8; t++) begin
      got = obs_c(); want = model(t, 2, 1, 1, 1'b0); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL loop_clear k=%0d t=%0d: got %s want %s", k, t, fmt(got), fmt(want)); end
      c_loop = (t >= k) ? 1'b0 : 1'b1;
      tick();
    end
    c_loop  = 1'b1;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int t = 0; t <= 8; t++) begin
      got = obs_c(); want = model(t, 2, 1, 1, 1'b1); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL loop_held t=%0d: got %s want %s", t, fmt(got), fmt(want)); end
      tick();
    end
    c_stop = 1'b1;
    tick();
    c_stop = 1'b0;
  endtask

  initial begin
    a_rst_n = 1'b0; a_start = 1'b0; a_stop = 1'b0; a_loop = 1'b0;
    b_rst_n = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_loop = 1'b0;
    c_rst_n = 1'b0; c_start = 1'b0; c_stop = 1'b0; c_loop = 1'b0;
    test_reset();
    test_one_shot();
    test_stop();
    test_start_collision();
    test_loop();
    test_async_reset();
    test_loop_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
